// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller:
// FSM state encoding, PC-select codes, register-index width and the
// bundled per-cycle control word with its canonical values.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

  // One cycle's worth of pipeline-register controls.
  typedef struct packed {
    logic       pc_we;
    logic       ifid_we;
    logic       idex_we;
    logic       exmem_we;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;
    logic [1:0] pc_sel;
  } ctrl_t;

  // Everything advances, nothing flushed, sequential fetch.
  function automatic ctrl_t ctrl_advance();
    ctrl_t c;
    c          = '0;
    c.pc_we    = 1'b1;
    c.ifid_we  = 1'b1;
    c.idex_we  = 1'b1;
    c.exmem_we = 1'b1;
    c.pc_sel   = PC_SEL_SEQ;
    return c;
  endfunction

  // Whole pipe held; a bubble is pushed into MEM/WB so the stalled
  // memory instruction does not write back repeatedly.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c             = '0;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bus between the datapath (master) and the hazard controller
// (slave): EX/MEM and ID/EX hazard sources in, register controls out.
`timescale 1ns/1ps
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic                 idex_memread;
  logic [REG_IDX_W-1:0] idex_rt;
  logic [REG_IDX_W-1:0] ifid_rs;
  logic [REG_IDX_W-1:0] ifid_rt;
  logic                 exmem_jump;
  logic                 exmem_branch;
  logic                 exmem_zero;
  logic                 exmem_memread;
  logic                 exmem_memwrite;
  logic                 mem_ready;

  logic                 pc_we;
  logic                 ifid_we;
  logic                 idex_we;
  logic                 exmem_we;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 exmem_flush;
  logic                 memwb_flush;
  logic [1:0]           pc_sel;
  logic                 mem_err;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport master (
    output idex_memread, idex_rt, ifid_rs, ifid_rt,
           exmem_jump, exmem_branch, exmem_zero,
           exmem_memread, exmem_memwrite, mem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           pc_sel, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt,
           exmem_jump, exmem_branch, exmem_zero,
           exmem_memread, exmem_memwrite, mem_ready,
    output pc_we, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           pc_sel, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the instruction in IF/ID reads the register a load
// in ID/EX is about to write. $zero is never a real dependency.
`timescale 1ns/1ps
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 i_idex_memread,
  input  logic [REG_IDX_W-1:0] i_idex_rt,
  input  logic [REG_IDX_W-1:0] i_ifid_rs,
  input  logic [REG_IDX_W-1:0] i_ifid_rt,
  output logic                 o_load_use
);

  logic w_rt_nonzero;
  logic w_src_match;

  assign w_rt_nonzero = (i_idex_rt != '0);
  assign w_src_match  = (i_idex_rt == i_ifid_rs) | (i_idex_rt == i_ifid_rt);
  assign o_load_use   = i_idex_memread & w_rt_nonzero & w_src_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Drives PC / IF/ID / ID/EX / EX/MEM enables, per-stage flushes and the
// PC select; handles load-use bubbles, MEM-stage redirects and stalled
// data-memory accesses with a timeout into a sticky error state.
// Optional statistics counters: define PIPE_HAZARD_CTRL_STATS_EN.
`timescale 1ns/1ps
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX_V = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_e            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;

  state_e            w_nxt_state;
  logic [WAIT_W-1:0] w_nxt_wait;
  logic              w_mem_op;
  logic              w_redirect;
  logic              w_load_use;
  ctrl_t             w_run_ctrl;
  logic              w_run_redirect;
  ctrl_t             w_ctrl;
  logic              w_redirect_taken;

  assign w_mem_op   = bus.exmem_memread | bus.exmem_memwrite;
  assign w_redirect = bus.exmem_jump | (bus.exmem_branch & bus.exmem_zero);

  load_use_detect u_load_use_detect (
    .i_idex_memread (bus.idex_memread),
    .i_idex_rt      (bus.idex_rt),
    .i_ifid_rs      (bus.ifid_rs),
    .i_ifid_rt      (bus.ifid_rt),
    .o_load_use     (w_load_use)
  );

  // Controls for a cycle with no memory stall: redirect outranks load-use
  // because the dependent instruction is flushed by the redirect anyway.
  always_comb begin
    w_run_ctrl     = ctrl_advance();
    w_run_redirect = 1'b0;
    if (w_redirect) begin
      w_run_ctrl.pc_sel      = bus.exmem_jump ? PC_SEL_JUMP : PC_SEL_BRANCH;
      w_run_ctrl.ifid_flush  = 1'b1;
      w_run_ctrl.idex_flush  = 1'b1;
      w_run_ctrl.exmem_flush = 1'b1;
      w_run_redirect         = 1'b1;
    end else if (w_load_use) begin
      w_run_ctrl.pc_we      = 1'b0;
      w_run_ctrl.ifid_we    = 1'b0;
      w_run_ctrl.idex_flush = 1'b1;
    end
  end

  // State-dependent control selection and next-state / wait-count logic.
  always_comb begin
    w_ctrl           = ctrl_advance();
    w_nxt_state      = r_state;
    w_nxt_wait       = r_wait_cnt;
    w_redirect_taken = 1'b0;
    if (reset) begin
      w_ctrl = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_op && !bus.mem_ready) begin
            w_ctrl      = ctrl_freeze();
            w_nxt_state = MEM_WAIT;
            w_nxt_wait  = WAIT_ONE;
          end else begin
            w_ctrl           = w_run_ctrl;
            w_redirect_taken = w_run_redirect;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            // Completion cycle behaves like RUN with the access done.
            w_ctrl           = w_run_ctrl;
            w_redirect_taken = w_run_redirect;
            w_nxt_state      = RUN;
            w_nxt_wait       = '0;
          end else begin
            w_ctrl = ctrl_freeze();
            if (r_wait_cnt == WAIT_MAX_V) begin
              w_nxt_state = ERR;
            end else begin
              w_nxt_wait = r_wait_cnt + WAIT_ONE;
            end
          end
        end
        ERR: begin
          w_ctrl = ctrl_freeze();
        end
        default: begin
          w_ctrl      = ctrl_freeze();
          w_nxt_state = RUN;
          w_nxt_wait  = '0;
        end
      endcase
    end
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_wait_cnt <= w_nxt_wait;
      if (w_nxt_state == ERR) begin
        r_mem_err <= 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Free-running (wrapping) statistics: PC-held cycles and redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_we) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect_taken) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  logic w_unused_redirect;
  assign w_unused_redirect = w_redirect_taken;
  assign bus.stall_cnt     = '0;
  assign bus.flush_cnt     = '0;
`endif

  assign bus.pc_we       = w_ctrl.pc_we;
  assign bus.ifid_we     = w_ctrl.ifid_we;
  assign bus.idex_we     = w_ctrl.idex_we;
  assign bus.exmem_we    = w_ctrl.exmem_we;
  assign bus.ifid_flush  = w_ctrl.ifid_flush;
  assign bus.idex_flush  = w_ctrl.idex_flush;
  assign bus.exmem_flush = w_ctrl.exmem_flush;
  assign bus.memwb_flush = w_ctrl.memwb_flush;
  assign bus.pc_sel      = w_ctrl.pc_sel;
  assign bus.mem_err     = r_mem_err;

endmodule
